// File: rtl/keypad_event_ctrl_if.sv
// Byte-wide register bus between the CPU side and the keypad event controller.
// Handshake: bus_rd/bus_wr are single-cycle strobes qualified by bus_sel and always accepted (no ready); bus_rdata is valid from the edge that samples bus_rd until the next read.
interface keypad_event_ctrl_if;
  logic       bus_sel;
  logic       bus_rd;
  logic       bus_wr;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       irq;

  modport master (
    output bus_sel, bus_rd, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata, irq
  );

  modport slave (
    input  bus_sel, bus_rd, bus_wr, bus_addr, bus_wdata,
    output bus_rdata, irq
  );
endinterface

// File: rtl/keypad_event_ctrl.sv
// Converts the scanner's level key code into press/repeat events, queues them in a small FIFO
// and exposes the queue through a 4-register byte bus with a level interrupt.
module keypad_event_ctrl #(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          RELEASE_CYCLES = 16,
  parameter logic [23:0] REPEAT_DELAY   = 24'd600000,
  parameter logic [23:0] REPEAT_PERIOD  = 24'd150000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             key_code,
  keypad_event_ctrl_if.slave     bus,
  output logic                   state_dbg_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RELEASE_CYCLES) + 1;

  typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [23:0]   rep_q, rep_d;
  logic          rpt_q, rpt_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          rep_en_q, rep_en_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic       push, push_ok, pop, pop_req, ovf_set, ovf_clr, rd_strobe, wr_strobe;
  logic       empty, full;
  logic [7:0] push_code;
  logic [3:0] count4;
  logic       unused_wdata;

  assign unused_wdata = ^bus.bus_wdata[6:2];

  // Key event FSM: press / change / release / auto-repeat.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rel_d     = rel_q;
    rep_d     = rep_q;
    rpt_d     = rpt_q;
    push      = 1'b0;
    push_code = key_code;
    case (state_q)
      S_IDLE: begin
        if (key_code != 8'd0) begin
          push    = 1'b1;
          cur_d   = key_code;
          state_d = S_HELD;
          rel_d   = '0;
          rep_d   = '0;
          rpt_d   = 1'b0;
        end
      end
      S_HELD: begin
        if (key_code == 8'd0) begin
          if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
            state_d = S_IDLE;
            rel_d   = '0;
            rep_d   = '0;
            rpt_d   = 1'b0;
          end else begin
            rel_d = rel_q + RW'(1);
          end
        end else if (key_code != cur_q) begin
          push  = 1'b1;
          cur_d = key_code;
          rel_d = '0;
          rep_d = '0;
          rpt_d = 1'b0;
        end else begin
          rel_d = '0;
          if (rep_en_q) begin
            if (rep_q == (rpt_q ? (REPEAT_PERIOD - 24'd1) : (REPEAT_DELAY - 24'd1))) begin
              push      = 1'b1;
              push_code = cur_q;
              rep_d     = '0;
              rpt_d     = 1'b1;
            end else begin
              rep_d = rep_q + 24'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rep_en_q) begin
      rep_d = '0;
      rpt_d = 1'b0;
    end
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign rd_strobe = bus.bus_sel & bus.bus_rd;
  assign wr_strobe = bus.bus_sel & bus.bus_wr;
  assign pop_req   = rd_strobe & (bus.bus_addr == 2'd0);
  assign pop       = pop_req & ~empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok   = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign ovf_clr   = wr_strobe & (bus.bus_addr == 2'd1) & bus.bus_wdata[7];
  assign count4    = 4'(count_q);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    irq_en_d = irq_en_q;
    rep_en_d = rep_en_q;
    if (wr_strobe && bus.bus_addr == 2'd2) begin
      irq_en_d = bus.bus_wdata[0];
      rep_en_d = bus.bus_wdata[1];
    end
    last_d  = push_ok ? push_code : last_q;
    irq_d   = irq_en_d & (count_d != '0);
    rdata_d = rdata_q;
    if (rd_strobe) begin
      case (bus.bus_addr)
        2'd0:    rdata_d = empty ? 8'd0 : mem_q[rd_ptr_q];
        2'd1:    rdata_d = {ovf_q, full, empty, (state_q == S_HELD), count4};
        2'd2:    rdata_d = {6'b0, rep_en_q, irq_en_q};
        default: rdata_d = last_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      rel_q    <= '0;
      rep_q    <= '0;
      rpt_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      rep_en_q <= 1'b0;
      last_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rel_q    <= rel_d;
      rep_q    <= rep_d;
      rpt_q    <= rpt_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      rep_en_q <= rep_en_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.irq       = irq_q;
  assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed scenarios plus randomized key/bus traffic, checked against a queue-based event model.
module tb_keypad_event_ctrl;
  localparam int          DEPTH = 4;
  localparam int          REL   = 4;
  localparam int          DEL   = 20;
  localparam int          PER   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_code = 8'd0;
  logic       state_dbg;

  keypad_event_ctrl_if bif ();

  keypad_event_ctrl #(
    .FIFO_DEPTH(DEPTH), .RELEASE_CYCLES(REL),
    .REPEAT_DELAY(24'(DEL)), .REPEAT_PERIOD(24'(PER))
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .bus(bif), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] exp_q[$];
  bit         m_held, m_rpt, m_ovf, m_irq_en, m_rep_en, m_irq;
  logic [7:0] m_cur, m_last, m_rdata;
  int         m_zeros, m_age;
  logic [7:0] kc = 8'd0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_held = 0; m_rpt = 0; m_ovf = 0; m_irq_en = 0; m_rep_en = 0; m_irq = 0;
    m_cur = 0; m_last = 0; m_rdata = 0; m_zeros = 0; m_age = 0;
  endtask

  task automatic model_step(input logic [7:0] key, input bit rd, input bit wr,
                            input logic [1:0] addr, input logic [7:0] wd);
    bit         do_push = 0;
    bit         ovf_set = 0;
    logic [7:0] code = 8'd0;
    int         sz = exp_q.size();
    if (rd) begin
      case (addr)
        2'd0: m_rdata = (sz > 0) ? exp_q.pop_front() : 8'd0;
        2'd1: m_rdata = {m_ovf, sz == DEPTH, sz == 0, m_held, 4'(sz)};
        2'd2: m_rdata = {6'b0, m_rep_en, m_irq_en};
        default: m_rdata = m_last;
      endcase
    end
    if (!m_held) begin
      if (key != 0) begin
        do_push = 1; code = key; m_held = 1; m_cur = key; m_zeros = 0; m_age = 0; m_rpt = 0;
      end
    end else if (key == 0) begin
      m_zeros++;
      if (m_zeros == REL) begin m_held = 0; m_zeros = 0; m_age = 0; m_rpt = 0; end
    end else if (key != m_cur) begin
      do_push = 1; code = key; m_cur = key; m_zeros = 0; m_age = 0; m_rpt = 0;
    end else begin
      m_zeros = 0;
      if (m_rep_en) begin
        m_age++;
        if (m_age == (m_rpt ? PER : DEL)) begin do_push = 1; code = m_cur; m_age = 0; m_rpt = 1; end
      end
    end
    if (!m_rep_en) begin m_age = 0; m_rpt = 0; end
    if (do_push) begin
      if (exp_q.size() < DEPTH) begin exp_q.push_back(code); m_last = code; end
      else ovf_set = 1;
    end
    if (wr && addr == 2'd1 && wd[7]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (wr && addr == 2'd2) begin m_irq_en = wd[0]; m_rep_en = wd[1]; end
    m_irq = m_irq_en && (exp_q.size() > 0);
  endtask

  // driver: one bus cycle, model update at the edge, compare #1 after it
  task automatic op(input logic [7:0] key, input bit rd, input bit wr,
                    input logic [1:0] addr, input logic [7:0] wd);
    kc = key;
    key_code      = key;
    bif.bus_sel   = rd | wr;
    bif.bus_rd    = rd;
    bif.bus_wr    = wr;
    bif.bus_addr  = addr;
    bif.bus_wdata = wd;
    @(posedge clk);
    model_step(key, rd, wr, addr, wd);
    #1;
    check("irq", {7'b0, bif.irq}, {7'b0, m_irq});
    check("held", {7'b0, state_dbg}, {7'b0, m_held});
    if (rd) check($sformatf("rdata_a%0d", addr), bif.bus_rdata, m_rdata);
    bif.bus_sel = 1'b0; bif.bus_rd = 1'b0; bif.bus_wr = 1'b0;
  endtask

  task automatic idle(input int n, input logic [7:0] key);
    for (int i = 0; i < n; i++) op(key, 0, 0, 2'd0, 8'd0);
  endtask

  task automatic rd_expect(input logic [1:0] addr, input logic [7:0] exp, input string tag);
    op(kc, 1, 0, addr, 8'd0);
    check(tag, bif.bus_rdata, exp);
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [7:0] wd);
    op(kc, 0, 1, addr, wd);
  endtask

  initial begin
    bif.bus_sel = 1'b0; bif.bus_rd = 1'b0; bif.bus_wr = 1'b0;
    bif.bus_addr = 2'd0; bif.bus_wdata = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", bif.bus_rdata, 8'd0);
    check("rst_irq", {7'b0, bif.irq}, 8'd0);
    rst_n = 1'b1;
    rd_expect(2'd1, 8'h20, "rst_status");
    rd_expect(2'd3, 8'h00, "rst_last");

    // 1: single press, irq, pop, release
    wr_reg(2'd2, 8'h01);
    idle(10, 8'd49);
    idle(4, 8'd0);
    rd_expect(2'd1, 8'h01, "t1_status");
    check("t1_irq_on", {7'b0, bif.irq}, 8'd1);
    rd_expect(2'd0, 8'd49, "t1_pop");
    check("t1_irq_off", {7'b0, bif.irq}, 8'd0);

    // 2: short gap is not a release
    idle(2, 8'd49); idle(3, 8'd0); idle(2, 8'd49); idle(4, 8'd0);
    rd_expect(2'd1, 8'h01, "t2_count");
    rd_expect(2'd0, 8'd49, "t2_pop");

    // 3: direct code change
    idle(3, 8'd50); idle(3, 8'd53); idle(4, 8'd0);
    rd_expect(2'd0, 8'd50, "t3_pop0");
    rd_expect(2'd0, 8'd53, "t3_pop1");
    rd_expect(2'd1, 8'h20, "t3_empty");
    rd_expect(2'd0, 8'd0, "empty_pop");

    // 4: overflow and clear
    for (int c = 49; c < 55; c++) begin idle(2, 8'(c)); idle(4, 8'd0); end
    rd_expect(2'd1, 8'hC4, "t4_ovf");
    wr_reg(2'd1, 8'h80);
    rd_expect(2'd1, 8'h44, "t4_clr");

    // 6: pop and press together while full
    op(8'd55, 1, 0, 2'd0, 8'd0);
    check("t6_head", bif.bus_rdata, 8'd49);
    rd_expect(2'd1, 8'h54, "t6_status");
    rd_expect(2'd0, 8'd50, "t6_d0");
    rd_expect(2'd0, 8'd51, "t6_d1");
    rd_expect(2'd0, 8'd52, "t6_d2");
    rd_expect(2'd0, 8'd55, "t6_d3");
    idle(4, 8'd0);

    // empty FIFO: pop returns 0 while the simultaneous push lands
    op(8'd70, 1, 0, 2'd0, 8'd0);
    check("pp_empty", bif.bus_rdata, 8'd0);
    rd_expect(2'd0, 8'd70, "pp_push");
    idle(4, 8'd0);

    // 5: auto-repeat
    wr_reg(2'd2, 8'h03);
    idle(45, 8'd65);
    idle(4, 8'd0);
    rd_expect(2'd1, 8'h44, "t5_count");
    for (int i = 0; i < 4; i++) rd_expect(2'd0, 8'd65, $sformatf("t5_ev%0d", i));

    // 7: reset with events queued
    idle(2, 8'd66); idle(4, 8'd0); idle(2, 8'd67); idle(4, 8'd0); idle(2, 8'd68); idle(4, 8'd0);
    rd_expect(2'd3, 8'd68, "t7_last");
    rd_expect(2'd2, 8'h03, "t7_ctrl");
    check("t7_irq_pre", {7'b0, bif.irq}, 8'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t7_irq", {7'b0, bif.irq}, 8'd0);
    check("t7_rdata", bif.bus_rdata, 8'd0);
    model_reset();
    kc = 8'd0; key_code = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_expect(2'd1, 8'h20, "t7_empty");
    rd_expect(2'd3, 8'd0, "t7_last_rst");
    rd_expect(2'd2, 8'd0, "t7_ctrl_rst");

    // randomized traffic against the model
    for (int seg = 0; seg < 80; seg++) begin
      int         r   = $urandom_range(0, 4);
      int         len = $urandom_range(1, 35);
      logic [7:0] key = (r == 0) ? 8'd0 : 8'(8'd64 + r);
      for (int i = 0; i < len; i++) begin
        int p = $urandom_range(0, 11);
        if (p < 3)       op(key, 1, 0, 2'($urandom_range(0, 3)), 8'd0);
        else if (p == 3) op(key, 0, 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        else if (p == 4) op(key, 1, 0, 2'd0, 8'd0);
        else             op(key, 0, 0, 2'd0, 8'd0);
      end
    end
    while (exp_q.size() > 0) op(8'd0, 1, 0, 2'd0, 8'd0);
    rd_expect(2'd0, 8'd0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
